profiler_frame_streamer: RTL
============================

# profiler_frame_streamer

Downstream consumer of the instruction profiler's eight 32-bit counters. On a snapshot request it latches all counters atomically into shadow registers. It then streams them as one 10-word frame over a 32-bit valid/ready interface: header, eight counters, XOR checksum. The frame feeds the host readout path (UART/bus bridge), so the profiler keeps counting while a coherent snapshot drains at the consumer's pace.

## Interface
Parameters:
- MAGIC, 16'hABAC, upper 16 bits of the header word.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_word_counter  input  32  counter word index 1.
- store_word_counter  input  32  counter word index 2.
- addition_counter  input  32  counter word index 3.
- subtraction_counter  input  32  counter word index 4.
- branch_counter  input  32  counter word index 5.
- jump_counter  input  32  counter word index 6.
- system_privilege_counter  input  32  counter word index 7.
- atomic_counter  input  32  counter word index 8.
- snapshot_req  input  1  request a frame; sampled every cycle.
- clear_overrun  input  1  clears sticky overrun.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  32  frame word.
- out_valid  output  1  out_data is valid.
- out_last  output  1  current word is the checksum (word 9).
- busy  output  1  a frame is captured and not fully transferred.
- overrun  output  1  sticky; a snapshot_req was dropped.

## Operation
- States: IDLE, HEADER, DATA, CHECKSUM. A 3-bit index tracks counter words 0–7 in DATA.
- IDLE + snapshot_req=1:
  - At that edge, latch all eight counter inputs into shadow registers.
  - Latch seq into the header.
  - Go to HEADER.
  - seq increments.
- Header word = {MAGIC, seq_at_capture[7:0], 8'd8}.
  - First frame after reset carries seq 0.
  - seq is 8 bits and wraps 255 -> 0.
- Frame order: header, then shadow counters in port-list order (load_word first, atomic last), then checksum.
- Checksum = XOR of the header and all eight shadow words. It is computed incrementally as each word transfers, or from the shadow registers; the result must be identical either way.
- Transfer occurs on any edge with out_valid=1 and out_ready=1. Each transfer advances to the next word:
  - HEADER -> DATA at index 0.
  - DATA index 7 -> CHECKSUM.
  - CHECKSUM -> IDLE.
- Stall rule: while out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays high. out_valid never drops mid-frame.
- Shadow registers do not change during a frame. Counter inputs changing mid-frame have no effect.
- snapshot_req in any state other than IDLE:
  - The request is dropped.
  - overrun is set to 1.
  - seq does not change.
  - This includes the cycle in which the checksum transfers.
- overrun clears on clear_overrun=1. If clear_overrun and a dropping snapshot_req occur in the same cycle, set wins.
- In IDLE: out_valid=0, out_last=0, out_data=0.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, seq=0, state=IDLE, shadow registers=0.
- All outputs are registered; there is no combinational path from out_ready or snapshot_req to any output.
- Latency:
  - snapshot_req is sampled at edge N.
  - out_valid=1 with the header is visible after edge N (cycle N+1).
  - busy=1 in the same cycle.
- Throughput: with out_ready held at 1, the frame occupies exactly 10 consecutive cycles (N+1 .. N+10).
- out_last=1 only in the checksum cycle(s).
- After the checksum transfers at edge M:
  - busy=0 and out_valid=0 from cycle M+1.
  - A snapshot_req sampled at edge M+1 is accepted, so the minimum frame-to-frame gap is one idle cycle.
- rst=1 at any time, including mid-frame, returns the block to the reset values at the next edge. The partial frame is abandoned; no checksum is emitted.

## Test plan
- Basic frame:
  - Stimulus: counters 1..8 (load_word=1 … atomic=8), out_ready=1, snapshot_req pulse.
  - Required: 10 words: 32'hABAC0008, 1, 2, 3, 4, 5, 6, 7, 8, 32'hABAC0008^8, with out_last only on the 10th word.
- Coherency:
  - Stimulus: capture with counters all 32'h11111111, then change the inputs to 32'hFFFFFFFF on the next cycle.
  - Required: all eight data words are 32'h11111111; checksum = 32'hABAC0008.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,… during a frame.
  - Required: out_data and out_valid hold through stalls; exactly 10 transfers; the word sequence is identical to the no-stall run.
- Overrun:
  - Stimulus: snapshot_req during word 4, and again in the checksum cycle.
  - Required: frame unaffected; overrun=1; the next frame header carries seq 1, not 2 or 3; clear_overrun returns overrun to 0.
- Sequence wrap:
  - Stimulus: 257 back-to-back frames.
  - Required: headers carry seq 0..255, then 0 again. Each new frame's header appears 2 cycles after the previous checksum transfer.
- Reset mid-frame:
  - Stimulus: rst asserted for 1 cycle during word 5.
  - Required: next cycle out_valid=0, busy=0, overrun=0; the next frame has seq 0 and a correct checksum.

Source files
------------

// File: rtl/profiler_frame_streamer.sv
// Snapshots the eight instruction-profiler counters atomically and streams them
// as a 10-word valid/ready frame: header, eight counters, XOR checksum.
module profiler_frame_streamer #(
  parameter logic [15:0] MAGIC = 16'hABAC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] load_word_counter,
  input  logic [31:0] store_word_counter,
  input  logic [31:0] addition_counter,
  input  logic [31:0] subtraction_counter,
  input  logic [31:0] branch_counter,
  input  logic [31:0] jump_counter,
  input  logic [31:0] system_privilege_counter,
  input  logic [31:0] atomic_counter,
  input  logic        snapshot_req,
  input  logic        clear_overrun,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned W       = 32;
  localparam int unsigned NUM_CNT = 8;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECKSUM} state_t;

  state_t         state, state_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     seq, seq_n;
  logic [W-1:0]   chk, chk_n;
  logic [W-1:0]   shadow [NUM_CNT];
  logic [W-1:0]   out_data_n;
  logic           out_valid_n, out_last_n, busy_n, overrun_n;
  logic           capture_c;
  logic [W-1:0]   cnt_c [NUM_CNT];
  logic [W-1:0]   hdr_c, cnt_xor_c;

  assign cnt_c[0] = load_word_counter;
  assign cnt_c[1] = store_word_counter;
  assign cnt_c[2] = addition_counter;
  assign cnt_c[3] = subtraction_counter;
  assign cnt_c[4] = branch_counter;
  assign cnt_c[5] = jump_counter;
  assign cnt_c[6] = system_privilege_counter;
  assign cnt_c[7] = atomic_counter;

  assign hdr_c     = {MAGIC, seq, 8'd8};
  // Checksum is fixed at capture time since the shadow words never change mid-frame.
  assign cnt_xor_c = cnt_c[0] ^ cnt_c[1] ^ cnt_c[2] ^ cnt_c[3]
                   ^ cnt_c[4] ^ cnt_c[5] ^ cnt_c[6] ^ cnt_c[7];

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    seq_n       = seq;
    chk_n       = chk;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    busy_n      = busy;
    overrun_n   = overrun;
    capture_c   = 1'b0;

    if (clear_overrun)
      overrun_n = 1'b0;
    if (snapshot_req && (state != IDLE))
      overrun_n = 1'b1;

    unique case (state)
      IDLE: begin
        if (snapshot_req) begin
          capture_c   = 1'b1;
          state_n     = HEADER;
          seq_n       = seq + 8'd1;
          chk_n       = hdr_c ^ cnt_xor_c;
          out_data_n  = hdr_c;
          out_valid_n = 1'b1;
          out_last_n  = 1'b0;
          busy_n      = 1'b1;
        end
      end
      HEADER: begin
        if (out_ready) begin
          state_n    = DATA;
          idx_n      = 3'd0;
          out_data_n = shadow[0];
        end
      end
      DATA: begin
        if (out_ready) begin
          if (idx == 3'd7) begin
            state_n    = CHECKSUM;
            out_data_n = chk;
            out_last_n = 1'b1;
          end else begin
            idx_n      = idx + 3'd1;
            out_data_n = shadow[idx_n];
          end
        end
      end
      CHECKSUM: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_data_n  = '0;
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          busy_n      = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      seq       <= 8'd0;
      chk       <= '0;
      shadow    <= '{default: '0};
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      seq       <= seq_n;
      chk       <= chk_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
      overrun   <= overrun_n;
      if (capture_c)
        shadow <= cnt_c;
    end
  end

endmodule
